// File: rtl/syst_mm_sequencer_pkg.sv
// syst_pkg: shared addresses, state encoding and operand packing helpers for the matrix sequencer
package syst_pkg;

    localparam logic [31:0] SYST_ADDR_ROW = 32'd0;
    localparam logic [31:0] SYST_ADDR_RES = 32'd4;
    localparam logic [31:0] SYST_ADDR_W0  = 32'd8;

    typedef enum logic [3:0] {
        IDLE, LOAD, SETUP, ACCESS, GAP, DRAIN, RSETUP, RACCESS, PUSH
    } state_t;

    // Column j of B, with row k's element j landing in byte k (B3 on top).
    function automatic logic [31:0] pack_col(input logic [3:0][31:0] b, input logic [1:0] j);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = b[k][31 - 8*int'(j) -: 8];
        return w;
    endfunction

    function automatic logic [31:0] rev_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/syst_mm_sequencer_apb_master.sv
// syst_apb_master: single APB transfer engine with SETUP/ACCESS/GAP phases and an ACCESS timeout
module syst_apb_master
    import syst_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic        m_sel_o,
    output logic        m_enable_o,
    output logic        m_we_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ready_i
);

    state_t     phase, phase_nx;
    logic [9:0] cnt;
    logic       we_r;
    logic       accept;

    // A new request may overlap the GAP cycle of the previous one.
    assign accept     = start && (phase == IDLE || phase == GAP);
    assign done       = phase == ACCESS && m_ready_i;
    assign timeout    = phase == ACCESS && !m_ready_i && cnt == 10'(TIMEOUT - 1);
    assign rdata      = m_dat_i;
    assign m_sel_o    = phase == SETUP || phase == ACCESS;
    assign m_enable_o = phase == ACCESS;
    assign m_we_o     = we_r && m_sel_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= IDLE;
            cnt     <= '0;
            we_r    <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
        end else begin
            phase <= phase_nx;
            cnt   <= phase == ACCESS ? cnt + 10'd1 : '0;
            if (accept) begin
                we_r    <= we;
                m_adr_o <= adr;
                if (we) m_dat_o <= wdata;
            end
        end
    end

    always_comb begin
        phase_nx = phase == SETUP  ? ACCESS :
                   phase == ACCESS ? (done ? GAP : timeout ? IDLE : ACCESS) :
                   accept          ? SETUP : IDLE;
    end

endmodule

// File: rtl/syst_mm_sequencer.sv
// syst_mm_sequencer: streams a 4x4 job into the systolic array over APB and streams the result rows out
module syst_mm_sequencer
    import syst_pkg::*;
#(
    parameter int DRAIN_CYCLES = 12,
    parameter int TIMEOUT      = 64
) (
    input  logic        p_clk_i,
    input  logic        p_rst_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_data_i,
    output logic        ld_ready_o,
    output logic        res_valid_o,
    output logic [31:0] res_data_o,
    output logic        res_last_o,
    input  logic        res_ready_i,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic        m_sel_o,
    output logic        m_enable_o,
    output logic        m_we_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ready_i,
    output logic        busy_o,
    output logic        err_o
);

    state_t           state, state_nx;
    logic [2:0]       cnt;
    logic [7:0]       dcnt;
    logic [3:0][31:0] a, b;
    logic             start, done, timeout, ld_hs, res_hs;
    logic [31:0]      adr, wdata, rdata;

    assign ld_ready_o  = state == IDLE || state == LOAD;
    assign ld_hs       = ld_valid_i && ld_ready_o;
    assign res_valid_o = state == PUSH;
    assign res_hs      = res_valid_o && res_ready_i;
    assign res_last_o  = res_valid_o && cnt == 3'd3;
    assign busy_o      = state != IDLE;
    assign start       = state == SETUP || state == RSETUP;
    // cnt is the word index while loading, the write index while writing and the row index while reading.
    assign wdata       = cnt[2] ? rev_bytes(a[cnt[1:0]]) : pack_col(b, cnt[1:0]);
    assign adr         = state == RSETUP ? SYST_ADDR_RES :
                         cnt[2] ? SYST_ADDR_ROW : SYST_ADDR_W0 + {28'd0, cnt[1:0], 2'b00};

    syst_apb_master #(.TIMEOUT(TIMEOUT)) u_apb (
        .clk        (p_clk_i),
        .rst        (p_rst_i),
        .start      (start),
        .we         (state == SETUP),
        .adr        (adr),
        .wdata      (wdata),
        .done       (done),
        .rdata      (rdata),
        .timeout    (timeout),
        .m_adr_o    (m_adr_o),
        .m_dat_o    (m_dat_o),
        .m_sel_o    (m_sel_o),
        .m_enable_o (m_enable_o),
        .m_we_o     (m_we_o),
        .m_dat_i    (m_dat_i),
        .m_ready_i  (m_ready_i)
    );

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            dcnt       <= '0;
            a          <= '0;
            b          <= '0;
            res_data_o <= '0;
            err_o      <= 1'b0;
        end else begin
            state <= state_nx;
            dcnt  <= state == DRAIN ? dcnt + 8'd1 : 8'd0;
            if (ld_hs && cnt[2]) b[cnt[1:0]] <= ld_data_i;
            if (ld_hs && !cnt[2]) a[cnt[1:0]] <= ld_data_i;
            if (ld_hs || (state == ACCESS && done) || res_hs) cnt <= (res_hs && cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
            if (timeout) cnt <= '0;
            if (timeout) err_o <= 1'b1;
            if (state == RACCESS && done) res_data_o <= rdata;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, LOAD: state_nx = ld_hs ? (cnt == 3'd7 ? SETUP : LOAD) : state;
            SETUP:      state_nx = ACCESS;
            ACCESS:     state_nx = timeout ? IDLE : done ? (cnt == 3'd7 ? DRAIN : SETUP) : ACCESS;
            DRAIN:      state_nx = dcnt == 8'(DRAIN_CYCLES - 1) ? RSETUP : DRAIN;
            RSETUP:     state_nx = RACCESS;
            RACCESS:    state_nx = timeout ? IDLE : done ? PUSH : RACCESS;
            PUSH:       state_nx = res_hs ? (cnt == 3'd3 ? IDLE : RSETUP) : PUSH;
            default:    state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_syst_mm_sequencer.sv
// tb_syst_mm_sequencer: directed jobs against an APB array model with hand-computed results
module tb_syst_mm_sequencer;

    localparam int DRAIN = 12;
    localparam int TMO   = 64;

    typedef logic [31:0] quad_t [4];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid_i = 1'b0;
    logic [31:0] ld_data_i = '0;
    logic        ld_ready_o;
    logic        res_valid_o;
    logic [31:0] res_data_o;
    logic        res_last_o;
    logic        res_ready_i = 1'b0;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_sel_o;
    logic        m_enable_o;
    logic        m_we_o;
    logic [31:0] m_dat_i = '0;
    logic        m_ready_i = 1'b0;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // slave / array model state
    logic [31:0] rows[4];
    logic [31:0] cols[4];
    int          row_ptr = 0;
    int          res_ptr = 0;
    int          nxfer = 0;
    int          acc_n = 0;
    int          hang_n = 0;
    logic        hang_en = 1'b0;
    logic [31:0] hang_adr = 32'd16;
    logic        jitter = 1'b0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    int          log_cyc[$];
    int          first_ld_cyc = 0;
    int          last_res_cyc = 0;

    quad_t ja1 = '{32'h07040403, 32'h01050501, 32'h07000204, 32'h01020402};
    quad_t jb1 = '{32'h01040506, 32'h05040800, 32'h01060207, 32'h02030100};
    quad_t jr1 = '{32'h464E4D25, 32'h29383921, 32'h382B3411, 32'h221F2A13};
    quad_t ja2 = '{32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
    quad_t jr2 = '{32'h06050401, 32'h00080405, 32'h07020601, 32'h00010302};
    quad_t jf  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    quad_t jr3 = '{32'h04040404, 32'h04040404, 32'h04040404, 32'h04040404};

    int          exp_adr[12] = '{8, 12, 16, 20, 0, 0, 0, 0, 4, 4, 4, 4};
    logic [31:0] exp_dat[8]  = '{32'h02010501, 32'h03060404, 32'h01020805, 32'h00070006,
                                 32'h03040407, 32'h01050501, 32'h04020007, 32'h02040201};

    syst_mm_sequencer #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO)) dut (
        .p_clk_i     (clk),
        .p_rst_i     (rst),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_ready_o  (ld_ready_o),
        .res_valid_o (res_valid_o),
        .res_data_o  (res_data_o),
        .res_last_o  (res_last_o),
        .res_ready_i (res_ready_i),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_sel_o     (m_sel_o),
        .m_enable_o  (m_enable_o),
        .m_we_o      (m_we_o),
        .m_dat_i     (m_dat_i),
        .m_ready_i   (m_ready_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] model_row(input int r);
        logic [31:0] v;
        logic [7:0]  s;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            s = '0;
            for (int k = 0; k < 4; k++) s = s + 8'(rows[r][8*k +: 8] * cols[c][8*k +: 8]);
            v[8*c +: 8] = s;
        end
        return v;
    endfunction

    // APB slave: decides PREADY on the falling edge; the transfer completes on the next rising edge.
    always @(negedge clk) begin
        if (m_sel_o === 1'b1 && m_enable_o === 1'b1) begin
            if (hang_en && m_adr_o == hang_adr) begin
                m_ready_i = 1'b0;
                hang_n++;
            end else if (acc_n < (jitter ? nxfer % 4 : 0)) begin
                m_ready_i = 1'b0;
                acc_n++;
            end else begin
                m_ready_i = 1'b1;
                acc_n = 0;
                if (m_we_o && m_adr_o == 32'd0) begin
                    rows[row_ptr] = m_dat_o;
                    row_ptr = (row_ptr + 1) % 4;
                end else if (m_we_o && m_adr_o >= 32'd8 && m_adr_o <= 32'd20) begin
                    if (m_adr_o == 32'd8) begin
                        row_ptr = 0;
                        res_ptr = 0;
                    end
                    cols[int'((m_adr_o - 32'd8) >> 2)] = m_dat_o;
                end else if (!m_we_o) begin
                    m_dat_i = model_row(res_ptr);
                    res_ptr = (res_ptr + 1) % 4;
                end
                log_adr.push_back(m_adr_o);
                log_dat.push_back(m_dat_o);
                log_we.push_back(m_we_o);
                log_cyc.push_back(cyc);
                nxfer++;
            end
        end else begin
            m_ready_i = jitter;
            acc_n = 0;
        end
    end

    task automatic send_job(input quad_t a, input quad_t b, input int gap);
        int t;
        for (int i = 0; i < 8; i++) begin
            repeat ((gap != 0) ? i % 3 : 0) @(negedge clk);
            ld_valid_i = 1'b1;
            ld_data_i = (i < 4) ? a[i] : b[i - 4];
            t = 0;
            while (!ld_ready_o && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) begin
                checks++;
                failures++;
                $display("FAIL ld_wait word%0d: ld_ready_o=%b after %0d cycles, required 1", i, ld_ready_o, t);
                ld_valid_i = 1'b0;
                return;
            end
            @(negedge clk);
            if (i == 0) first_ld_cyc = cyc;
            ld_valid_i = 1'b0;
        end
    endtask

    task automatic collect(input quad_t exp, input int stall_row, input int tag);
        int  t;
        int  n0;
        bit  ok;
        for (int r = 0; r < 4; r++) begin
            t = 0;
            while (!res_valid_o && t < 2000) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (res_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL res_wait job%0d row%0d: res_valid_o=%b, required 1", tag, r, res_valid_o);
                return;
            end
            checks++;
            if ({res_last_o, res_data_o} !== {r == 3, exp[r]}) begin
                failures++;
                $display("FAIL res_row job%0d row%0d: last=%b data=%h, required last=%b data=%h",
                         tag, r, res_last_o, res_data_o, r == 3, exp[r]);
            end
            if (r == stall_row) begin
                n0 = nxfer;
                ok = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (res_data_o !== exp[r] || res_valid_o !== 1'b1 || busy_o !== 1'b1 ||
                        m_sel_o !== 1'b0 || nxfer != n0) ok = 1'b0;
                end
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL stall_hold job%0d row%0d: data=%h valid=%b busy=%b sel=%b xfers=%0d, required data=%h valid=1 busy=1 sel=0 xfers=%0d",
                             tag, r, res_data_o, res_valid_o, busy_o, m_sel_o, nxfer, exp[r], n0);
                end
            end
            res_ready_i = 1'b1;
            @(negedge clk);
            res_ready_i = 1'b0;
            last_res_cyc = cyc;
        end
        checks++;
        if ({busy_o, ld_ready_o, res_valid_o} !== 3'b010) begin
            failures++;
            $display("FAIL job_end job%0d: busy=%b ld_ready=%b res_valid=%b, required busy=0 ld_ready=1 res_valid=0",
                     tag, busy_o, ld_ready_o, res_valid_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ld_ready_o, res_valid_o, res_last_o, res_data_o, m_adr_o, m_dat_o,
             m_sel_o, m_enable_o, m_we_o, busy_o, err_o} !== {1'b1, 103'd0}) begin
            failures++;
            $display("FAIL reset_outputs: ld_ready=%b res_valid=%b adr=%h dat=%h sel=%b en=%b busy=%b err=%b, required ld_ready=1 all else 0",
                     ld_ready_o, res_valid_o, m_adr_o, m_dat_o, m_sel_o, m_enable_o, busy_o, err_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ld_ready_o, busy_o, m_sel_o} !== 3'b100) begin
            failures++;
            $display("FAIL idle_after_reset: ld_ready=%b busy=%b sel=%b, required 1 0 0", ld_ready_o, busy_o, m_sel_o);
        end
    endtask

    task automatic test_single_job();
        int base;
        int n0;
        base = log_adr.size();
        n0 = nxfer;
        send_job(ja1, jb1, 0);
        collect(jr1, -1, 1);
        checks++;
        if (nxfer - n0 != 12) begin
            failures++;
            $display("FAIL xfer_count job1: %0d transfers, required 12", nxfer - n0);
        end
        for (int i = 0; i < 12 && base + i < log_adr.size(); i++) begin
            checks++;
            if (i < 8 ? ({log_we[base+i], log_adr[base+i], log_dat[base+i]} !== {1'b1, 32'(exp_adr[i]), exp_dat[i]})
                      : ({log_we[base+i], log_adr[base+i]} !== {1'b0, 32'(exp_adr[i])})) begin
                failures++;
                $display("FAIL apb_xfer%0d: we=%b adr=%h dat=%h, required we=%b adr=%h dat=%h",
                         i, log_we[base+i], log_adr[base+i], log_dat[base+i], i < 8, exp_adr[i], i < 8 ? exp_dat[i] : 32'h0);
            end
        end
        if (base + 8 < log_cyc.size()) begin
            checks++;
            if (log_cyc[base+8] - log_cyc[base+7] < DRAIN + 2) begin
                failures++;
                $display("FAIL drain_gap: %0d cycles between last write and first read, required >= %0d",
                         log_cyc[base+8] - log_cyc[base+7], DRAIN + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        send_job(ja1, jb1, 0);
        collect(jr1, 1, 2);
    endtask

    task automatic test_back_to_back();
        send_job(ja1, jb1, 0);
        fork
            collect(jr1, -1, 3);
            send_job(ja2, jb1, 0);
        join
        checks++;
        if (first_ld_cyc <= last_res_cyc) begin
            failures++;
            $display("FAIL b2b_ld_ready: job2 first word at cycle %0d, required after job1 last result at cycle %0d",
                     first_ld_cyc, last_res_cyc);
        end
        collect(jr2, -1, 4);
    endtask

    task automatic test_timeout();
        int t;
        bit quiet;
        hang_en = 1'b1;
        hang_adr = 32'd16;
        hang_n = 0;
        send_job(ja1, jb1, 0);
        t = 0;
        while (!(m_enable_o === 1'b1 && m_adr_o == 32'd16) && t < 500) begin
            @(negedge clk);
            t++;
        end
        while (m_enable_o === 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (hang_n != TMO) begin
            failures++;
            $display("FAIL timeout_len: ACCESS held %0d cycles, required %0d", hang_n, TMO);
        end
        checks++;
        if ({m_sel_o, m_enable_o, err_o, busy_o, ld_ready_o} !== 5'b00101) begin
            failures++;
            $display("FAIL timeout_state: sel=%b en=%b err=%b busy=%b ld_ready=%b, required 0 0 1 0 1",
                     m_sel_o, m_enable_o, err_o, busy_o, ld_ready_o);
        end
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (res_valid_o !== 1'b0 || m_sel_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL timeout_quiet: result or APB activity after abort, required none");
        end
        hang_en = 1'b0;
        send_job(ja2, jb1, 0);
        collect(jr2, -1, 5);
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: err_o=%b, required 1", err_o);
        end
    endtask

    task automatic test_reset_drain();
        int n0;
        int t;
        bit quiet;
        n0 = nxfer;
        send_job(ja1, jb1, 0);
        t = 0;
        while (nxfer < n0 + 8 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ld_ready_o, res_valid_o, res_last_o, res_data_o, m_adr_o, m_dat_o,
             m_sel_o, m_enable_o, m_we_o, busy_o, err_o} !== {1'b1, 103'd0}) begin
            failures++;
            $display("FAIL drain_reset: ld_ready=%b res_valid=%b adr=%h dat=%h sel=%b en=%b busy=%b err=%b, required ld_ready=1 all else 0",
                     ld_ready_o, res_valid_o, m_adr_o, m_dat_o, m_sel_o, m_enable_o, busy_o, err_o);
        end
        n0 = nxfer;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (m_sel_o !== 1'b0 || res_valid_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || nxfer != n0) begin
            failures++;
            $display("FAIL drain_reset_quiet: %0d transfers after reset, required 0", nxfer - n0);
        end
        send_job(jf, jf, 0);
        collect(jr3, -1, 6);
    endtask

    task automatic test_jitter();
        int n0;
        jitter = 1'b1;
        n0 = nxfer;
        send_job(ja1, jb1, 1);
        collect(jr1, -1, 7);
        checks++;
        if (nxfer - n0 != 12) begin
            failures++;
            $display("FAIL jitter_xfers: %0d transfers, required 12", nxfer - n0);
        end
        jitter = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_drain();
        test_jitter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
